ps2_move_decoder: RTL and testbench
===================================

// Module: ps2_move_decoder
// PURPOSE
//  Converts the raw PS/2 byte stream (received_data/received_data_en) into clean maze moves.
//  - Parses E0 (extended) and F0 (break) prefixes and tracks held state for Up/Down/Left/Right/Enter.
//  - Issues one move per make code, plus optional auto-repeat while a key is held.
//  - Moves go out over a valid/ready handshake to the box draw/animation engine. It sits between
//    PS2_Controller and that engine.
// PARAMETERS
//  REPEAT_DELAY   25_000_000  cycles a key is held before the first auto-repeat move (0.5 s @50 MHz)
//  REPEAT_PERIOD  5_000_000   cycles between later auto-repeat moves (0.1 s @50 MHz)
//  PREFIX_TIMEOUT 100_000     cycles a pending E0/F0 prefix stays live before it is discarded
//  CNT_W          25          width of the repeat and timeout counters; must hold the largest count
// PORTS
//  iClock       in   1  system clock (50 MHz)
//  iResetn      in   1  asynchronous, active-low reset
//  iData        in   8  PS/2 byte from PS2_Controller
//  iDataEn      in   1  1-cycle strobe: iData is valid
//  iMoveReady   in   1  draw engine accepts a move this cycle
//  oMoveValid   out  1  a move is pending
//  oMoveDir     out  2  pending direction: 0=Up 1=Down 2=Left 3=Right; stable while oMoveValid=1
//  oEnter       out  1  1-cycle pulse on an Enter make code
//  oHeld        out  5  held state {Enter,Right,Left,Down,Up}, bit0=Up; drives LEDR
//  oOverrun     out  1  sticky; set when a pending move is overwritten; cleared only by reset
// BEHAVIOUR
//  Reset (async, iResetn=0): parser IDLE, counters 0, every output 0.
//  Parser FSM, advances only on iDataEn=1:
//   IDLE: E0->EXT; F0->BRK; other byte = non-extended make.
//   EXT:  F0->EXT_BRK; other byte = extended make, then IDLE.
//   BRK:  any byte = non-extended break, then IDLE.
//   EXT_BRK: any byte = extended break, then IDLE.
//   In EXT, BRK or EXT_BRK with no iDataEn for PREFIX_TIMEOUT cycles -> IDLE, byte discarded.
//  Key map:
//   - Extended 75/72/6B/74 = Up/Down/Left/Right.
//   - Non-extended 5A = Enter.
//   - All other codes only return the parser to IDLE.
//  Make, cycle after the last byte:
//   - Set the oHeld bit.
//   - Arrow key: queue a move and restart the repeat counter.
//   - Enter: pulse oEnter.
//   - Typematic re-makes of an already-held key do not queue a move and do not restart the counter.
//  Break: clear the oHeld bit, cycle after the byte.
//  Repeat source:
//   - The most recently made arrow key that is still held.
//   - If it is released, repeat stops; it does not fall back to another held key.
//  Move buffer, one entry:
//   - A queued move loads oMoveDir and sets oMoveValid on the next cycle.
//   - Transfer happens when oMoveValid & iMoveReady; oMoveValid drops on the next cycle unless a
//     new move is queued in that same cycle, in which case it stays 1 with the new direction.
//   - Queuing while valid and not ready: latest move wins, oMoveDir is replaced, oOverrun is set.
//  Simultaneous make and repeat tick in one cycle: the make wins and the counter restarts.
//  Reset mid-frame: the partial prefix is dropped; no move is generated.
// CONFIGURATION
//  `AUTO_REPEAT_EN defined:
//   - The repeat counter is compiled in.
//   - While the repeat source is held: first repeat move after REPEAT_DELAY cycles, then one every
//     REPEAT_PERIOD cycles.
//   - Repeat moves use the same buffer and overwrite rules as make moves.
//  `AUTO_REPEAT_EN undefined: no counter; exactly one move per make; oHeld still tracked.
// STRUCTURE
//  Shared package ps2_pkg:
//   - Scan-code constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_UP=8'h75, SC_DN=8'h72, SC_LT=8'h6B,
//     SC_RT=8'h74, SC_ENTER=8'h5A.
//   - Direction encoding DIR_UP..DIR_RIGHT.
//   - Parser state encoding.
//  Sub-module ps2_prefix_parser: FSM plus timeout; emits code[7:0], is_ext, is_break, strobe.
//  Top level holds the key map, held register, repeat counter and move buffer.
// TESTING
//  1. Bytes E0,75 with iMoveReady=1 -> oMoveValid=1 for one cycle, oMoveDir=0, oHeld=5'b00001.
//  2. E0,F0,75 after test 1 -> oHeld=0; no move is issued.
//  3. iMoveReady=0; send E0,74 then E0,6B -> oMoveValid stays 1, oMoveDir=2, oOverrun=1.
//  4. E0 followed by a PREFIX_TIMEOUT gap, then 75 -> no move, oHeld=0; 75 decodes as
//     non-extended and is ignored.
//  5. With AUTO_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=4: hold E0,72 for 30 cycles with
//     ready=1 -> moves at cycles 1, 11, 15, 19, 23, 27 (Down); none after the break.
//  6. 5A, then iResetn pulled low while E0 is pending -> one oEnter pulse, then all outputs 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: scan codes, move directions, prefix-parser states.
package ps2_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DN    = 8'h72;
    localparam logic [7:0] SC_LT    = 8'h6B;
    localparam logic [7:0] SC_RT    = 8'h74;
    localparam logic [7:0] SC_ENTER = 8'h5A;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } pstate_e;

    // Bit positions in the held vector; arrows share their direction encoding.
    localparam logic [2:0] KEY_ENTER = 3'd4;

endpackage

// File: rtl/ps2_prefix_parser.sv
// E0/F0 prefix parser: reports each complete scan code with its extended/break
// flags as a combinational strobe in the cycle the final byte arrives.
module ps2_prefix_parser
    import ps2_pkg::*;
#(
    parameter int PREFIX_TIMEOUT = 100_000,
    parameter int CNT_W          = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       data_en,
    output logic       strobe,
    output logic [7:0] code,
    output logic       is_ext,
    output logic       is_break
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

    pstate_e          state, state_nxt;
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PS_IDLE;
            tmo_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Idle gap counter only runs while a prefix is pending.
            if (data_en || state == PS_IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        strobe    = 1'b0;
        is_ext    = 1'b0;
        is_break  = 1'b0;
        code      = data;
        if (data_en) begin
            case (state)
                PS_IDLE: begin
                    if (data == SC_EXT)      state_nxt = PS_EXT;
                    else if (data == SC_BRK) state_nxt = PS_BRK;
                    else                     strobe    = 1'b1;
                end
                PS_EXT: begin
                    if (data == SC_BRK) begin
                        state_nxt = PS_EXT_BRK;
                    end else begin
                        strobe    = 1'b1;
                        is_ext    = 1'b1;
                        state_nxt = PS_IDLE;
                    end
                end
                PS_BRK: begin
                    strobe    = 1'b1;
                    is_break  = 1'b1;
                    state_nxt = PS_IDLE;
                end
                default: begin
                    strobe    = 1'b1;
                    is_ext    = 1'b1;
                    is_break  = 1'b1;
                    state_nxt = PS_IDLE;
                end
            endcase
        end else if (state != PS_IDLE && tmo_cnt == TMO_LAST) begin
            state_nxt = PS_IDLE;
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 byte stream to maze moves: key map, held keys, one-entry move buffer.
// Define AUTO_REPEAT_EN to compile in typematic-style auto-repeat of the last arrow.
module ps2_move_decoder
    import ps2_pkg::*;
#(
    parameter int REPEAT_DELAY   = 25_000_000,
    parameter int REPEAT_PERIOD  = 5_000_000,
    parameter int PREFIX_TIMEOUT = 100_000,
    parameter int CNT_W          = 25
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic [7:0] iData,
    input  logic       iDataEn,
    input  logic       iMoveReady,
    output logic       oMoveValid,
    output logic [1:0] oMoveDir,
    output logic       oEnter,
    output logic [4:0] oHeld,
    output logic       oOverrun
);

    logic       evt_stb, evt_ext, evt_brk;
    logic [7:0] evt_code;

    ps2_prefix_parser #(
        .PREFIX_TIMEOUT (PREFIX_TIMEOUT),
        .CNT_W          (CNT_W)
    ) u_parser (
        .clk      (iClock),
        .rst_n    (iResetn),
        .data     (iData),
        .data_en  (iDataEn),
        .strobe   (evt_stb),
        .code     (evt_code),
        .is_ext   (evt_ext),
        .is_break (evt_brk)
    );

    logic       key_hit;
    logic [2:0] key_idx;

    always_comb begin
        key_hit = 1'b0;
        key_idx = 3'd0;
        if (evt_stb) begin
            if (evt_ext) begin
                case (evt_code)
                    SC_UP:   begin key_hit = 1'b1; key_idx = 3'(DIR_UP);    end
                    SC_DN:   begin key_hit = 1'b1; key_idx = 3'(DIR_DOWN);  end
                    SC_LT:   begin key_hit = 1'b1; key_idx = 3'(DIR_LEFT);  end
                    SC_RT:   begin key_hit = 1'b1; key_idx = 3'(DIR_RIGHT); end
                    default: ;
                endcase
            end else if (evt_code == SC_ENTER) begin
                key_hit = 1'b1;
                key_idx = KEY_ENTER;
            end
        end
    end

    logic make, brk, arrow_make, is_enter;
    dir_e mk_dir;

    assign is_enter   = (key_idx == KEY_ENTER);
    assign make       = key_hit & ~evt_brk;
    assign brk        = key_hit & evt_brk;
    // Typematic re-makes of a held key neither queue a move nor restart repeat.
    assign arrow_make = make & ~is_enter & ~oHeld[key_idx];
    assign mk_dir     = dir_e'(key_idx[1:0]);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oHeld  <= '0;
            oEnter <= 1'b0;
        end else begin
            oEnter <= make & is_enter;
            if (make) oHeld[key_idx] <= 1'b1;
            if (brk)  oHeld[key_idx] <= 1'b0;
        end
    end

    logic rpt_tick;
    dir_e rpt_dir;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             rpt_act, rpt_first, src_brk;
    logic [CNT_W-1:0] rpt_cnt;

    assign src_brk  = brk & ~is_enter & (key_idx[1:0] == rpt_dir);
    assign rpt_tick = rpt_act & ~src_brk &
                      (rpt_cnt == (rpt_first ? DLY_LAST : PER_LAST));

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            rpt_act   <= 1'b0;
            rpt_first <= 1'b0;
            rpt_dir   <= DIR_UP;
            rpt_cnt   <= '0;
        end else if (arrow_make) begin
            rpt_act   <= 1'b1;
            rpt_first <= 1'b1;
            rpt_dir   <= mk_dir;
            rpt_cnt   <= '0;
        end else if (src_brk) begin
            // No fallback to another still-held arrow.
            rpt_act <= 1'b0;
            rpt_cnt <= '0;
        end else if (rpt_tick) begin
            rpt_first <= 1'b0;
            rpt_cnt   <= '0;
        end else if (rpt_act) begin
            rpt_cnt <= rpt_cnt + 1'b1;
        end
    end
`else
    logic [CNT_W-1:0] unused_rpt_cfg;
    assign unused_rpt_cfg = CNT_W'(REPEAT_DELAY) ^ CNT_W'(REPEAT_PERIOD);
    assign rpt_tick       = 1'b0;
    assign rpt_dir        = DIR_UP;
`endif

    logic push;
    dir_e push_dir;

    assign push     = arrow_make | rpt_tick;
    assign push_dir = arrow_make ? mk_dir : rpt_dir;

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            oMoveValid <= 1'b0;
            oMoveDir   <= 2'd0;
            oOverrun   <= 1'b0;
        end else if (push) begin
            if (oMoveValid && !iMoveReady) oOverrun <= 1'b1;
            oMoveValid <= 1'b1;
            oMoveDir   <= push_dir;
        end else if (oMoveValid && iMoveReady) begin
            oMoveValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder with a move scoreboard and a decoupled monitor.
module tb_ps2_move_decoder;

    localparam int RD = 10;
    localparam int RP = 4;
    localparam int PT = 20;
    localparam int CW = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       den = 1'b0;
    logic       rdy = 1'b0;
    logic       mv_valid, enter, overrun;
    logic [1:0] mv_dir;
    logic [4:0] held;

    ps2_move_decoder #(
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .PREFIX_TIMEOUT (PT),
        .CNT_W          (CW)
    ) dut (
        .iClock     (clk),
        .iResetn    (rst_n),
        .iData      (data),
        .iDataEn    (den),
        .iMoveReady (rdy),
        .oMoveValid (mv_valid),
        .oMoveDir   (mv_dir),
        .oEnter     (enter),
        .oHeld      (held),
        .oOverrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] dir;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_enter = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted move is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (enter === 1'b1) n_enter++;
            if (mv_valid === 1'b1 && rdy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_move: dir %0d at cycle %0d, expected none", mv_dir, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("move_dir", 32'(mv_dir), 32'(e.dir));
                    if (e.cyc >= 0) check("move_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, output int at);
        @(posedge clk); #1;
        data = b;
        den  = 1'b1;
        at   = cyc;
        @(posedge clk); #1;
        den  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    int t, c0;

    initial begin
        // Reset state
        idle(3);
        check("rst_valid", 32'(mv_valid), 0);
        check("rst_dir", 32'(mv_dir), 0);
        check("rst_enter", 32'(enter), 0);
        check("rst_held", 32'(held), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        idle(2);

        // 1: extended Up make, ready high -> single move, Up held
        rdy = 1'b1;
        send(8'hE0, t);
        send(8'h75, t);
        sb.push_back('{2'd0, t + 1});
        check("t1_held", 32'(held), 32'b00001);
        idle(1);
        check("t1_valid_one_cycle", 32'(mv_valid), 0);

        // 2: extended Up break -> no move, nothing held
        send(8'hE0, t);
        send(8'hF0, t);
        send(8'h75, t);
        check("t2_held", 32'(held), 0);
        idle(3);

        // 3: stalled buffer, second move overwrites first
        rdy = 1'b0;
        send(8'hE0, t);
        send(8'h74, t);
        check("t3_valid_a", 32'(mv_valid), 1);
        check("t3_dir_a", 32'(mv_dir), 3);
        check("t3_overrun_a", 32'(overrun), 0);
        send(8'hE0, t);
        send(8'h6B, t);
        sb.push_back('{2'd2, -1});
        check("t3_valid_b", 32'(mv_valid), 1);
        check("t3_dir_b", 32'(mv_dir), 2);
        check("t3_overrun_b", 32'(overrun), 1);
        check("t3_held", 32'(held), 32'b01100);
        send(8'hE0, t); send(8'hF0, t); send(8'h6B, t);
        send(8'hE0, t); send(8'hF0, t); send(8'h74, t);
        check("t3_held_rel", 32'(held), 0);
        check("t3_dir_stall", 32'(mv_dir), 2);
        rdy = 1'b1;
        idle(2);
        check("t3_valid_drain", 32'(mv_valid), 0);

        // 4: E0 prefix times out, 75 then decodes non-extended and is ignored
        send(8'hE0, t);
        idle(PT + 5);
        send(8'h75, t);
        idle(3);
        check("t4_held", 32'(held), 0);
        check("t4_valid", 32'(mv_valid), 0);

        // 5: hold Down; typematic re-make mid-hold; break before the next tick
        send(8'hE0, t);
        send(8'h72, c0);
        sb.push_back('{2'd1, c0 + 1});
`ifdef AUTO_REPEAT_EN
        sb.push_back('{2'd1, c0 + 11});
        sb.push_back('{2'd1, c0 + 15});
        sb.push_back('{2'd1, c0 + 19});
        sb.push_back('{2'd1, c0 + 23});
        sb.push_back('{2'd1, c0 + 27});
`endif
        check("t5_held", 32'(held), 32'b00010);
        idle(2);
        send(8'hE0, t);
        send(8'h72, t);
        while (cyc < c0 + 24) begin @(posedge clk); #1; end
        send(8'hE0, t);
        send(8'hF0, t);
        send(8'h72, t);
        check("t5_break_cycle", t, c0 + 29);
        idle(30);
        check("t5_held_rel", 32'(held), 0);
        check("t5_sb_drained", sb.size(), 0);
        check("overrun_sticky", 32'(overrun), 1);

        // 6: Enter pulse, then reset while an E0 prefix is pending
        send(8'h5A, t);
        check("t6_held_enter", 32'(held), 32'b10000);
        idle(2);
        check("t6_enter_pulses", n_enter, 1);
        send(8'hE0, t);
        rst_n = 1'b0;
        #2;
        check("t6_rst_valid", 32'(mv_valid), 0);
        check("t6_rst_enter", 32'(enter), 0);
        check("t6_rst_held", 32'(held), 0);
        check("t6_rst_overrun", 32'(overrun), 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send(8'h75, t);
        idle(3);
        check("t6_no_ext_after_rst", 32'(held), 0);
        check("t6_valid", 32'(mv_valid), 0);

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
